// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the page register copies OAM_SIZE bytes
// from {page, 8'h00} into OAM, one read and one write cycle per byte.
module oam_dma #(
    parameter logic [15:0] REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_LOC  = 16'hFE00,
    parameter int          OAM_SIZE = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_we,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        dma_req,
    input  logic        dma_gnt,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_rdata,
    output logic        oam_we,
    output logic [15:0] oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        dma_active
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(OAM_SIZE - 1);

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic       start;

    assign start = reg_we && (reg_addr == REG_ADDR);

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        case (state_q)
            READ:  if (dma_gnt) state_d = WRITE;
            WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
        // A page write restarts from byte 0 regardless of where we are
        if (start) begin
            page_d  = reg_wdata;
            index_d = 8'd0;
            state_d = READ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            page_q  <= 8'h00;
            index_q <= 8'd0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
        end
    end

    assign reg_rdata  = (reg_addr == REG_ADDR) ? page_q : 8'h00;
    assign dma_active = (state_q != IDLE);
    assign dma_req    = (state_q == READ);
    assign dma_addr   = (state_q != IDLE) ? {page_q, index_q} : 16'h0000;

    // The byte being written is dropped if the CPU restarts the transfer now
    assign oam_we    = (state_q == WRITE) && !start;
    assign oam_addr  = (state_q == WRITE) ? (OAM_LOC + {8'h00, index_q}) : 16'h0000;
    assign oam_wdata = (state_q == WRITE) ? dma_rdata : 8'h00;

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter REG_ADDR, default 16'hFF46, CPU address of the DMA source-page register.
REQ-002 Parameter OAM_LOC, default 16'hFE00, base bus address of OAM.
REQ-003 Parameter OAM_SIZE, default 160, number of bytes copied per transfer.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 reg_we  input  1  CPU write strobe, one cycle.
REQ-007 reg_addr  input  16  CPU address.
REQ-008 reg_wdata  input  8  CPU write data.
REQ-009 reg_rdata  output  8  source-page register readback; valid when reg_addr==REG_ADDR, else 8'h00.
REQ-010 dma_req  output  1  request for the source bus.
REQ-011 dma_gnt  input  1  source bus granted this cycle.
REQ-012 dma_addr  output  16  source read address.
REQ-013 dma_rdata  input  8  source read data, valid the cycle after a granted read.
REQ-014 oam_we  output  1  OAM write strobe.
REQ-015 oam_addr  output  16  OAM write address, OAM_LOC + index.
REQ-016 oam_wdata  output  8  OAM write data.
REQ-017 dma_active  output  1  high while a transfer is in progress.

Function
REQ-018 The block SHALL hold an 8-bit page register, written when reg_we && reg_addr==REG_ADDR; its value SHALL be readable at any time, including mid-transfer.
REQ-019 The FSM SHALL have states IDLE, READ and WRITE, plus an 8-bit index counter.
REQ-020 A register write in cycle N SHALL load page=reg_wdata and index=0, and SHALL enter READ in cycle N+1 from any state.
REQ-021 In READ: dma_req=1 and dma_addr={page, index}.
  - dma_gnt=0: stay in READ (stall, no side effects).
  - dma_gnt=1: go to WRITE next cycle.
REQ-022 In WRITE: oam_we=1 for exactly one cycle, oam_addr=OAM_LOC+index, oam_wdata=dma_rdata captured this cycle.
  - index==OAM_SIZE-1: go to IDLE.
  - otherwise: index+1, go to READ.
REQ-023 A zero-stall transfer SHALL take exactly 2*OAM_SIZE cycles (320 at default) from the first READ to the return to IDLE.
REQ-024 dma_active SHALL be 1 in READ and WRITE and 0 in IDLE.
REQ-025 dma_req SHALL be 0 outside READ; oam_we SHALL be 0 outside WRITE.
REQ-026 A register write during READ or WRITE SHALL abort the current byte (no oam_we that cycle if in WRITE) and restart per REQ-020 with the new page.
REQ-027 The index SHALL never exceed OAM_SIZE-1; no OAM write SHALL go beyond OAM_LOC+OAM_SIZE-1.
REQ-028 Any page value 8'h00..8'hFF SHALL be accepted and used unmodified; the upper 8 bits of dma_addr SHALL be exactly page.
REQ-029 In IDLE, dma_addr, oam_addr and oam_wdata SHALL be 0.

Reset
REQ-030 While rst_n==0 at a clock edge, the block SHALL set state=IDLE, page=8'h00 and index=0; dma_req, oam_we and dma_active SHALL be 0 from the next cycle.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no further oam_we; after release the block SHALL stay in IDLE until a new register write.
REQ-032 A reg_we in the same cycle as rst_n==0 SHALL be ignored.

Verification
REQ-033 Source fills page 8'hC0 with byte i = i^8'h5A, dma_gnt tied 1, write 8'hC0 -> 160 oam_we pulses; pulse k at FE00+k carries k^8'h5A; dma_active high exactly 320 cycles.
REQ-034 dma_gnt low for 5 cycles at byte 10 -> READ holds dma_addr=16'hC00A for 5 cycles; total active time 325 cycles; data correct.
REQ-035 Rewrite to 8'hD0 after 50 bytes -> no further writes from C0xx; OAM indices restart at 0 from D000; 160 writes follow the rewrite.
REQ-036 rst_n low for 1 cycle at byte 80 -> no oam_we after reset; dma_active=0; reg_rdata at FF46 reads 8'h00.
REQ-037 Write 8'hFF, then read FF46 mid-transfer -> reg_rdata=8'hFF; last write at FE9F from FF9F; no write to FEA0.
REQ-038 Read at reg_addr other than FF46 -> reg_rdata=8'h00; reg_we to FF45 -> no transfer starts.
